offload_sync_trigger_gen: RTL and testbench
===========================================

// Module: offload_sync_trigger_gen
// PURPOSE
//  Conditions an external or software trigger into the one-shot/repeating sync pulse that drives
//  the data offload's hardware-sync input (sync_ext, sync_config=1) on the DAC side.
//  Sits directly upstream of data_offload: synchronises an asynchronous trigger pin, qualifies
//  the edge, and enforces arming and a holdoff window. Emits a clean sync pulse of fixed width.
// PARAMETERS
//  PULSE_WIDTH    2   sync_out high time in clk cycles (>=1)
//  HOLDOFF_WIDTH  16  width of cfg_holdoff
//  PERIOD_WIDTH   32  width of cfg_period (used only with OFFLOAD_SYNC_PERIODIC_EN)
//  COUNT_WIDTH    16  width of sync_count / drop_count
// PORTS
//  clk          in   1              destination-domain clock (same clock as data_offload DAC side)
//  rst          in   1              asynchronous, active-high reset
//  trig_in      in   1              external trigger pin, asynchronous to clk
//  sw_trig      in   1              software trigger, one clk-cycle pulse, already in clk domain
//  arm          in   1              one-cycle pulse: IDLE -> ARMED
//  disarm       in   1              one-cycle pulse: any state -> IDLE (pulse in flight completes)
//  cfg_edge     in   2              0 rising, 1 falling, 2 both, 3 reserved (treated as rising)
//  cfg_oneshot  in   1              1: return to IDLE after holdoff; 0: re-arm automatically
//  cfg_holdoff  in   HOLDOFF_WIDTH  cycles to ignore triggers after pulse end
//  cfg_period   in   PERIOD_WIDTH   auto-trigger period in cycles; 0 = disabled
//  sync_out     out  1              to data_offload sync_ext
//  armed        out  1              high in ARMED only
//  busy         out  1              high in PULSE or HOLDOFF
//  sync_count   out  COUNT_WIDTH    pulses emitted, wraps max->0
//  drop_count   out  COUNT_WIDTH    qualified triggers ignored in PULSE/HOLDOFF, saturates at max
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; all counters 0; synchroniser flops 0.
//  trig_in: 2-FF synchroniser, then edge detection per cfg_edge. Qualified edge is 1-cycle.
//  Latency: trig_in stable before clk edge N -> sync_out high after edge N+3; sw_trig at edge N
//    -> sync_out high after edge N+1.
//  FSM (registered outputs):
//   IDLE:    armed=0. arm -> ARMED. Triggers are ignored and not counted.
//   ARMED:   armed=1. Qualified edge | sw_trig | period tick -> PULSE, sync_count++.
//   PULSE:   sync_out=1 for exactly PULSE_WIDTH cycles. Then go to HOLDOFF; if cfg_holdoff==0,
//            go straight to the post-holdoff target.
//   HOLDOFF: down-count cfg_holdoff cycles (value latched at PULSE entry). At 0 -> IDLE if
//            cfg_oneshot, else ARMED.
//  Triggers in PULSE/HOLDOFF: drop_count++ once per qualified event. Never queued.
//  Simultaneous events:
//   arm & disarm -> disarm wins.
//   trigger & disarm in ARMED -> IDLE, no pulse.
//   disarm in PULSE -> finish the pulse, then IDLE (skip holdoff).
//   disarm in HOLDOFF -> IDLE next cycle.
//   edge & sw_trig in the same cycle -> one pulse.
//  cfg_* changes take effect at the next PULSE entry. cfg_edge is applied immediately.
// CONFIGURATION
//  OFFLOAD_SYNC_PERIODIC_EN defined:
//   - PERIOD_WIDTH down-counter is loaded with cfg_period-1 on every ARMED entry.
//   - Reaching 0 while ARMED raises an internal trigger.
//   - cfg_period==0 disables the counter.
//  Not defined: counter logic is absent and cfg_period is ignored (port kept for a stable interface).
// STRUCTURE
//  offload_sync_trigger_pkg:
//   - state enum {IDLE, ARMED, PULSE, HOLDOFF}
//   - EDGE_RISE/EDGE_FALL/EDGE_BOTH localparams
//  Sub-module offload_sync_edge_det: 2-FF synchroniser plus cfg_edge-selected 1-cycle edge pulse.
//  Top level: FSM, pulse/holdoff/period counters, statistics counters.
// TESTING
//  1. arm; trig_in 0->1 (cfg_edge=0, PULSE_WIDTH=2) -> sync_out high exactly 2 cycles, 3 cycles
//     after the edge; sync_count=1.
//  2. cfg_holdoff=100, cfg_oneshot=0; 3 trig edges 20 cycles apart -> 1 pulse; drop_count=2;
//     armed=1 again 100 cycles after pulse end.
//  3. cfg_oneshot=1; trigger -> pulse; after holdoff armed=0; second trigger -> no pulse,
//     drop_count unchanged.
//  4. arm & disarm same cycle -> stays IDLE. disarm mid-PULSE -> full 2-cycle pulse, then IDLE.
//  5. rst asserted mid-PULSE -> sync_out, counters, armed = 0 without waiting for clk.
//  6. PERIODIC_EN, cfg_period=50, cfg_holdoff=0, cfg_oneshot=0 -> pulse every 50+PULSE_WIDTH
//     cycles; 10 pulses -> sync_count=10.

Source files
------------

// File: rtl/offload_sync_trigger_pkg.sv
// Shared types and constants for the offload sync trigger generator.
// Optional build macro: OFFLOAD_SYNC_PERIODIC_EN (enables the auto-trigger period counter).
package offload_sync_trigger_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PULSE   = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    // cfg_edge encodings; the remaining code (3) behaves as EDGE_RISE.
    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;

    // PULSE and HOLDOFF both count as an in-flight sync event.
    function automatic logic is_busy(input state_e s);
        return (s == PULSE) || (s == HOLDOFF);
    endfunction

endpackage

// File: rtl/offload_sync_edge_det.sv
// Brings the asynchronous trigger pin into the clk domain through two flops and
// produces a registered one-cycle pulse on the edge selected by edge_sel_i.
// The edge selection is not latched: a change on edge_sel_i applies on the next clock.
module offload_sync_edge_det
    import offload_sync_trigger_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       trig_i,
    input  logic [1:0] edge_sel_i,
    output logic       edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic edge_q;
    logic edge_d;

    // Edge qualification from the synchronised level and its one-cycle-old copy
    always_comb begin
        case (edge_sel_i)
            EDGE_FALL: edge_d = ~sync2_q & prev_q;
            EDGE_BOTH: edge_d = sync2_q ^ prev_q;
            default:   edge_d = sync2_q & ~prev_q;
        endcase
    end

    // Synchroniser chain, history flop and registered edge pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= trig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/offload_sync_trigger_gen.sv
// Turns an external pin or software trigger into a fixed-width sync pulse for the
// data offload sync_ext input, with arming, holdoff and pulse/drop statistics.
// Optional build macro: OFFLOAD_SYNC_PERIODIC_EN adds a cfg_period auto-trigger;
// without it cfg_period is accepted but has no effect.
module offload_sync_trigger_gen
    import offload_sync_trigger_pkg::*;
#(
    parameter int PULSE_WIDTH   = 2,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int PERIOD_WIDTH  = 32,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trig_in,
    input  logic                     sw_trig,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic [1:0]               cfg_edge,
    input  logic                     cfg_oneshot,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic [PERIOD_WIDTH-1:0]  cfg_period,
    output logic                     sync_out,
    output logic                     armed,
    output logic                     busy,
    output logic [COUNT_WIDTH-1:0]   sync_count,
    output logic [COUNT_WIDTH-1:0]   drop_count
);

    localparam int                     PCNT_W    = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam logic [PCNT_W-1:0]      PCNT_LOAD = PCNT_W'(PULSE_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};

    state_e                   state_q, state_d;
    logic [PCNT_W-1:0]        pulse_cnt_q, pulse_cnt_d;
    logic [HOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLDOFF_WIDTH-1:0] holdoff_lat_q, holdoff_lat_d;
    logic                     oneshot_lat_q, oneshot_lat_d;
    logic                     kill_q, kill_d;
    logic [COUNT_WIDTH-1:0]   sync_cnt_q, sync_cnt_d;
    logic [COUNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic                     sync_q, armed_q, busy_q;

    logic                     pin_edge;
    logic                     period_tick;
    logic                     trig_any;

    offload_sync_edge_det u_edge_det (
        .clk_i      (clk),
        .rst_i      (rst),
        .trig_i     (trig_in),
        .edge_sel_i (cfg_edge),
        .edge_o     (pin_edge)
    );

`ifdef OFFLOAD_SYNC_PERIODIC_EN
    logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic                    period_en_q, period_en_d;

    // Reload on every ARMED entry, then count down while waiting for a trigger
    always_comb begin
        period_cnt_d = period_cnt_q;
        period_en_d  = period_en_q;
        if (state_d == ARMED && state_q != ARMED) begin
            period_cnt_d = cfg_period - PERIOD_WIDTH'(1);
            period_en_d  = (cfg_period != '0);
        end else if (state_q == ARMED && period_cnt_q != '0) begin
            period_cnt_d = period_cnt_q - PERIOD_WIDTH'(1);
        end
    end

    // Period counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_q <= '0;
            period_en_q  <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_d;
            period_en_q  <= period_en_d;
        end
    end

    assign period_tick = (state_q == ARMED) && period_en_q && (period_cnt_q == '0);
`else
    logic unused_cfg_period;
    assign unused_cfg_period = ^cfg_period;
    assign period_tick       = 1'b0;
`endif

    // Coincident sources collapse into a single trigger event
    assign trig_any = pin_edge | sw_trig | period_tick;

    // FSM next state, pulse/holdoff counting and statistics
    always_comb begin
        state_d       = state_q;
        pulse_cnt_d   = pulse_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        holdoff_lat_d = holdoff_lat_q;
        oneshot_lat_d = oneshot_lat_q;
        kill_d        = kill_q;
        sync_cnt_d    = sync_cnt_q;
        drop_cnt_d    = drop_cnt_q;

        if (is_busy(state_q) && trig_any && drop_cnt_q != CNT_MAX) begin
            drop_cnt_d = drop_cnt_q + COUNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (arm && !disarm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (disarm) begin
                    state_d = IDLE;
                end else if (trig_any) begin
                    state_d       = PULSE;
                    pulse_cnt_d   = PCNT_LOAD;
                    holdoff_lat_d = cfg_holdoff;
                    oneshot_lat_d = cfg_oneshot;
                    kill_d        = 1'b0;
                    sync_cnt_d    = sync_cnt_q + COUNT_WIDTH'(1);
                end
            end
            PULSE: begin
                if (pulse_cnt_q == '0) begin
                    if (kill_q || disarm) begin
                        state_d = IDLE;
                    end else if (holdoff_lat_q == '0) begin
                        state_d = oneshot_lat_q ? IDLE : ARMED;
                    end else begin
                        state_d    = HOLDOFF;
                        hold_cnt_d = holdoff_lat_q - HOLDOFF_WIDTH'(1);
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PCNT_W'(1);
                    if (disarm) begin
                        kill_d = 1'b1;
                    end
                end
            end
            HOLDOFF: begin
                if (disarm) begin
                    state_d = IDLE;
                end else if (hold_cnt_q == '0) begin
                    state_d = oneshot_lat_q ? IDLE : ARMED;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLDOFF_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, counters and outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pulse_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            holdoff_lat_q <= '0;
            oneshot_lat_q <= 1'b0;
            kill_q        <= 1'b0;
            sync_cnt_q    <= '0;
            drop_cnt_q    <= '0;
            sync_q        <= 1'b0;
            armed_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pulse_cnt_q   <= pulse_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            holdoff_lat_q <= holdoff_lat_d;
            oneshot_lat_q <= oneshot_lat_d;
            kill_q        <= kill_d;
            sync_cnt_q    <= sync_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            sync_q        <= (state_d == PULSE);
            armed_q       <= (state_d == ARMED);
            busy_q        <= is_busy(state_d);
        end
    end

    assign sync_out   = sync_q;
    assign armed      = armed_q;
    assign busy       = busy_q;
    assign sync_count = sync_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_offload_sync_trigger_gen.sv
// Directed bench for offload_sync_trigger_gen with a timestamp-based reference model.
// Optional build macro: OFFLOAD_SYNC_PERIODIC_EN (adds the periodic scenario).
module tb_offload_sync_trigger_gen;

    localparam int PW   = 2;
    localparam int HW   = 16;
    localparam int PRW  = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           trig_in, sw_trig, arm, disarm;
    logic [1:0]     cfg_edge;
    logic           cfg_oneshot;
    logic [HW-1:0]  cfg_holdoff;
    logic [PRW-1:0] cfg_period;
    logic           sync_out, armed, busy;
    logic [CW-1:0]  sync_count, drop_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int base  = 0;

    offload_sync_trigger_gen #(
        .PULSE_WIDTH   (PW),
        .HOLDOFF_WIDTH (HW),
        .PERIOD_WIDTH  (PRW),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig_in     (trig_in),
        .sw_trig     (sw_trig),
        .arm         (arm),
        .disarm      (disarm),
        .cfg_edge    (cfg_edge),
        .cfg_oneshot (cfg_oneshot),
        .cfg_holdoff (cfg_holdoff),
        .cfg_period  (cfg_period),
        .sync_out    (sync_out),
        .armed       (armed),
        .busy        (busy),
        .sync_count  (sync_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (event timestamps) ----------------
    bit          m_armed, m_busy, m_kill, m_oneshot, m_per_en;
    longint      m_pulse_until, m_hold_until, m_next_tick;
    int          m_sync, m_drop;
    bit [7:0]    sh;
    logic [1:0]  e_prev;

    function automatic bit qual(input logic [1:0] e, input bit newer, input bit older);
        case (e)
            2'd1:    return !newer && older;
            2'd2:    return newer != older;
            default: return newer && !older;
        endcase
    endfunction

    task automatic enter_armed();
        m_armed     = 1'b1;
        m_next_tick = cyc + cfg_period;
        m_per_en    = (cfg_period != 0);
    endtask

    always @(posedge clk) begin
        bit qe, tick, trig;
        cyc++;
        if (rst) begin
            m_armed = 0; m_busy = 0; m_kill = 0; m_oneshot = 0; m_per_en = 0;
            m_pulse_until = 0; m_hold_until = 0; m_next_tick = 0;
            m_sync = 0; m_drop = 0; sh = '0; e_prev = 2'd0;
        end else begin
            // a pin level seen at edge k-4/k-3 turns into a trigger at edge k
            qe     = qual(e_prev, sh[2], sh[3]);
            sh     = {sh[6:0], trig_in};
            e_prev = cfg_edge;
            tick   = 1'b0;
`ifdef OFFLOAD_SYNC_PERIODIC_EN
            tick = m_armed && m_per_en && (cyc == m_next_tick);
`endif
            trig = qe | sw_trig | tick;
            if (m_armed) begin
                if (disarm) m_armed = 0;
                else if (trig) begin
                    m_armed       = 0;
                    m_busy        = 1;
                    m_kill        = 0;
                    m_pulse_until = cyc + PW;
                    m_hold_until  = m_pulse_until + cfg_holdoff;
                    m_oneshot     = cfg_oneshot;
                    m_sync        = (m_sync + 1) & CMAX;
                end
            end else if (m_busy) begin
                if (trig && m_drop < CMAX) m_drop++;
                if (disarm && cyc <= m_pulse_until) m_kill = 1;
                if (disarm && cyc > m_pulse_until) m_busy = 0;
                else if (cyc == m_pulse_until && m_kill) m_busy = 0;
                else if (cyc == m_hold_until) begin
                    m_busy = 0;
                    if (!m_oneshot) enter_armed();
                end
            end else if (arm && !disarm) begin
                enter_armed();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("sync_out",   sync_out,   (m_busy && cyc < m_pulse_until) ? 1 : 0);
            check("armed",      armed,      m_armed);
            check("busy",       busy,       m_busy);
            check("sync_count", sync_count, m_sync);
            check("drop_count", drop_count, m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic goto(input int rel);
        while (cyc < base + rel) @(negedge clk);
    endtask

    task automatic mark();
        base = cyc + 1;
    endtask

    task automatic do_reset();
        trig_in = 0; sw_trig = 0; arm = 0; disarm = 0;
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic pulse_arm();
        arm = 1;
        @(negedge clk);
        arm = 0;
    endtask

    task automatic sw_pulse();
        sw_trig = 1;
        @(negedge clk);
        sw_trig = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; trig_in = 0; sw_trig = 0; arm = 0; disarm = 0;
        cfg_edge = 2'd0; cfg_oneshot = 0; cfg_holdoff = '0; cfg_period = '0;
        repeat (3) @(negedge clk);
        check("rst_sync",  sync_out,   0);
        check("rst_armed", armed,      0);
        check("rst_busy",  busy,       0);
        check("rst_scnt",  sync_count, 0);
        check("rst_dcnt",  drop_count, 0);

        // 1: latency and width of a pin-triggered pulse
        do_reset();
        cfg_holdoff = 16'd4;
        pulse_arm();
        check("t1_armed", armed, 1);
        trig_in = 1; mark();
        goto(2); check("t1_lat2", sync_out, 0);
        goto(3); check("t1_hi0", sync_out, 1);
        goto(4); check("t1_hi1", sync_out, 1); check("t1_cnt", sync_count, 1);
        goto(5); check("t1_lo", sync_out, 0); check("t1_busy", busy, 1);
        goto(8); check("t1_hold", armed, 0);
        goto(9); check("t1_rearm", armed, 1);
        trig_in = 0;
        goto(12);

        // 2: triggers during holdoff are dropped, not queued
        do_reset();
        cfg_holdoff = 16'd100; cfg_oneshot = 0;
        pulse_arm();
        trig_in = 1; mark();
        goto(10); trig_in = 0;
        goto(19); trig_in = 1;
        goto(30); trig_in = 0;
        goto(39); trig_in = 1;
        goto(50); trig_in = 0;
        goto(104); check("t2_hold_end", armed, 0);
        goto(105); check("t2_rearm", armed, 1);
        check("t2_drop", drop_count, 2); check("t2_cnt", sync_count, 1);

        // 3: one-shot returns to IDLE, later triggers are not counted
        do_reset();
        cfg_holdoff = 16'd10; cfg_oneshot = 1;
        pulse_arm();
        trig_in = 1; mark();
        goto(10); trig_in = 0;
        goto(14); check("t3_busy", busy, 1);
        goto(15); check("t3_idle", armed, 0); check("t3_nbusy", busy, 0);
        goto(29); trig_in = 1;
        goto(35); sw_pulse();
        goto(40); check("t3_cnt", sync_count, 1); check("t3_drop", drop_count, 0);
        // software trigger latency
        pulse_arm();
        check("t3_sw_pre", sync_out, 0);
        sw_trig = 1; mark();
        goto(0); sw_trig = 0; check("t3_sw_hi", sync_out, 1);
        goto(14); trig_in = 0;
        // pin edge and sw_trig landing on the same cycle give one pulse
        pulse_arm();
        trig_in = 1; mark();
        goto(2); sw_trig = 1;
        goto(3); sw_trig = 0;
        goto(4); check("t3_co_hi", sync_out, 1);
        goto(20); check("t3_co_cnt", sync_count, 3); check("t3_co_drop", drop_count, 0);

        // 4: arm/disarm interactions
        do_reset();
        cfg_holdoff = 16'd20; cfg_oneshot = 0;
        arm = 1; disarm = 1;
        @(negedge clk);
        arm = 0; disarm = 0;
        check("t4_armdis", armed, 0);
        pulse_arm();
        sw_trig = 1; mark();
        goto(0); sw_trig = 0; disarm = 1;
        goto(1); disarm = 0; check("t4_pulse_hold", sync_out, 1);
        goto(2); check("t4_end", sync_out, 0); check("t4_nbusy", busy, 0);
        check("t4_idle", armed, 0);
        pulse_arm();
        sw_trig = 1; mark();
        goto(0); sw_trig = 0;
        goto(5); disarm = 1;
        goto(6); disarm = 0; check("t4_hdis", busy, 0);
        pulse_arm();
        sw_trig = 1; disarm = 1;
        @(negedge clk);
        sw_trig = 0; disarm = 0;
        @(negedge clk);
        check("t4_trigdis", sync_count, 2); check("t4_trigdis_st", armed, 0);

        // 5: asynchronous reset in the middle of a pulse
        do_reset();
        pulse_arm();
        sw_trig = 1; mark();
        goto(0); sw_trig = 0; check("t5_hi", sync_out, 1);
        rst = 1;
        #1;
        check("t5_sync", sync_out, 0); check("t5_armed", armed, 0);
        check("t5_busy", busy, 0); check("t5_cnt", sync_count, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // drop_count saturates
        do_reset();
        cfg_holdoff = 16'd200; cfg_oneshot = 0;
        pulse_arm();
        sw_pulse();
        for (int i = 0; i < 20; i++) begin
            sw_pulse();
            @(negedge clk);
        end
        check("sat_drop", drop_count, CMAX); check("sat_cnt", sync_count, 1);

        // sync_count wraps
        do_reset();
        cfg_holdoff = 16'd0; cfg_oneshot = 0;
        pulse_arm();
        for (int i = 0; i < 16; i++) begin
            sw_pulse();
            repeat (3) @(negedge clk);
        end
        check("wrap_16", sync_count, 0);
        sw_pulse();
        repeat (3) @(negedge clk);
        check("wrap_17", sync_count, 1); check("wrap_drop", drop_count, 0);

        // edge selection: falling, both, reserved code
        do_reset();
        cfg_edge = 2'd1; cfg_holdoff = 16'd0; cfg_oneshot = 0;
        pulse_arm();
        trig_in = 1;
        repeat (6) @(negedge clk);
        trig_in = 0; mark();
        goto(2); check("fall_pre", sync_out, 0);
        goto(3); check("fall_hi", sync_out, 1);
        goto(6); cfg_edge = 2'd2;
        goto(8); trig_in = 1;
        goto(15); trig_in = 0;
        goto(22); cfg_edge = 2'd3;
        goto(23); trig_in = 1;
        goto(30); trig_in = 0;
        goto(40); check("edge_cnt", sync_count, 4);
        cfg_edge = 2'd0;

`ifdef OFFLOAD_SYNC_PERIODIC_EN
        // periodic auto-trigger: one pulse every period+PULSE_WIDTH cycles
        do_reset();
        cfg_period = 32'd50; cfg_holdoff = 16'd0; cfg_oneshot = 0;
        arm = 1; mark();
        goto(0); arm = 0;
        goto(49); check("per_pre", sync_out, 0);
        goto(50); check("per_hi", sync_out, 1);
        goto(517); check("per_cnt9", sync_count, 9);
        goto(518); check("per_cnt10", sync_count, 10);
        disarm = 1;
        @(negedge clk);
        disarm = 0;
        cfg_period = 32'd0;
        pulse_arm();
        mark();
        goto(120); check("per_off", sync_count, 10); check("per_off_armed", armed, 1);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
